pipe_ctrl_gen: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/pipe_hazard_cnt.sv | 13 +
 rtl/pipe_ctrl_gen.sv | 93 +++++++++
 tb/tb_pipe_ctrl_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcodes, forward selects, stage-register type and decode helpers
package pipe_ctrl_pkg;
  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] OPIMM  = 5'b00100;
  localparam logic [4:0] AUIPC  = 5'b00101;
  localparam logic [4:0] STORE  = 5'b01000;
  localparam logic [4:0] OP     = 5'b01100;
  localparam logic [4:0] LUI    = 5'b01101;
  localparam logic [4:0] BRANCH = 5'b11000;
  localparam logic [4:0] JALR   = 5'b11001;
  localparam logic [4:0] JAL    = 5'b11011;
  localparam logic [1:0] FWD_W  = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_RF = 2'd2;
  typedef struct packed {
    logic       valid;
    logic [4:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } stage_t;
  localparam stage_t NOP = '{1'b0, OPIMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0};
  function automatic logic uses_rs1(input logic [4:0] o);
    return o inside {LOAD, OPIMM, STORE, OP, BRANCH, JALR};
  endfunction
  function automatic logic uses_rs2(input logic [4:0] o);
    return o inside {OP, STORE, BRANCH};
  endfunction
  function automatic logic writes_rd(input logic [4:0] o);
    return o inside {LOAD, OPIMM, AUIPC, OP, LUI, JALR, JAL};
  endfunction
  function automatic logic hit(input stage_t p, input logic [4:0] idx);
    return p.valid & writes_rd(p.op) & (p.rd != 5'd0) & (p.rd == idx);
  endfunction
endpackage

// File: rtl/pipe_hazard_cnt.sv
// pipe_hazard_cnt: saturating event counter
module pipe_hazard_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  // count one per event cycle, stick at all-ones
  always_ff @(posedge clk)
    cnt <= rst ? '0 : (inc & ~&cnt) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: 5-stage pipeline control with hazards, forwarding, memory wait and counters
module pipe_ctrl_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int RIDX_W   = 5,
  parameter int DM_BYTES = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          op,
  input  logic [2:0]          f3,
  input  logic [6:0]          f7,
  input  logic [RIDX_W-1:0]   rd,
  input  logic [RIDX_W-1:0]   rs1,
  input  logic [RIDX_W-1:0]   rs2,
  input  logic                alu_out,
  input  logic                dm_ready,
  output logic                stall,
  output logic                next_pc_sel,
  output logic                flush,
  output logic                D_rs1_data_sel,
  output logic                D_rs2_data_sel,
  output logic [4:0]          E_op,
  output logic [2:0]          E_f3,
  output logic [6:0]          E_f7,
  output logic [1:0]          E_rs1_data_sel,
  output logic [1:0]          E_rs2_data_sel,
  output logic                E_alu_op1_sel,
  output logic                E_alu_op2_sel,
  output logic                E_jb_op1_sel,
  output logic [DM_BYTES-1:0] M_dm_w_en,
  output logic                M_dm_r_en,
  output logic [2:0]          W_f3,
  output logic                W_wb_en,
  output logic [RIDX_W-1:0]   W_rd_index,
  output logic                W_wb_data_sel,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt,
  output logic [CNT_W-1:0]    freeze_cnt
);
  stage_t d, e, m, w;
  logic w_held, freeze, redirect, load_use, store, unused_ok;
  assign d = '{1'b1, op, f3, f7, 5'(rd), 5'(rs1), 5'(rs2)};
  assign freeze   = m.valid & (m.op == LOAD | m.op == STORE) & ~dm_ready;
  assign redirect = ~freeze & e.valid & (e.op == JAL | e.op == JALR | (e.op == BRANCH & alu_out));
  assign load_use = ~freeze & ~redirect & e.valid & (e.op == LOAD) & (e.rd != 5'd0) &
                    ((uses_rs1(d.op) & (e.rd == d.rs1)) | (uses_rs2(d.op) & (e.rd == d.rs2)));
  // stage registers: hold on freeze, bubble E on redirect/load-use; w_held marks a repeated W
  always_ff @(posedge clk) begin
    if (rst) begin
      e <= NOP;
      m <= NOP;
      w <= NOP;
      w_held <= 1'b0;
    end else begin
      w_held <= freeze;
      if (!freeze) begin
        e <= (redirect | load_use) ? NOP : d;
        m <= e;
        w <= m;
      end
    end
  end
  assign stall          = freeze | load_use;
  assign next_pc_sel    = redirect;
  assign flush          = redirect;
  assign D_rs1_data_sel = hit(w, d.rs1);
  assign D_rs2_data_sel = hit(w, d.rs2);
  assign E_op           = e.valid ? e.op : '0;
  assign E_f3           = e.valid ? e.f3 : '0;
  assign E_f7           = e.valid ? e.f7 : '0;
  assign E_rs1_data_sel = hit(m, e.rs1) ? FWD_M : hit(w, e.rs1) ? FWD_W : FWD_RF;
  assign E_rs2_data_sel = hit(m, e.rs2) ? FWD_M : hit(w, e.rs2) ? FWD_W : FWD_RF;
  assign E_alu_op1_sel  = e.op == AUIPC | e.op == JAL | e.op == JALR;
  assign E_alu_op2_sel  = ~(e.op == OP | e.op == BRANCH);
  assign E_jb_op1_sel   = e.op != JALR;
  assign store          = m.valid & (m.op == STORE);
  assign M_dm_w_en      = ~store ? '0 :
                          m.f3 == 3'b000 ? DM_BYTES'(1) :
                          m.f3 == 3'b001 ? DM_BYTES'(3) :
                          m.f3 == 3'b010 ? DM_BYTES'(15) :
                          (m.f3 == 3'b011 && DM_BYTES == 8) ? '1 : '0;
  assign M_dm_r_en      = m.valid & (m.op == LOAD);
  assign W_f3           = w.valid ? w.f3 : '0;
  assign W_wb_en        = w.valid & writes_rd(w.op) & ~w_held;
  assign W_rd_index     = w.rd[RIDX_W-1:0];
  assign W_wb_data_sel  = w.op != LOAD;
  assign unused_ok      = ^{m.f7, m.rs1, m.rs2, w.f7, w.rs1, w.rs2, w.rd};
  pipe_hazard_cnt #(.W(CNT_W)) u_stall_cnt  (.clk(clk), .rst(rst), .inc(load_use), .cnt(stall_cnt));
  pipe_hazard_cnt #(.W(CNT_W)) u_flush_cnt  (.clk(clk), .rst(rst), .inc(redirect), .cnt(flush_cnt));
  pipe_hazard_cnt #(.W(CNT_W)) u_freeze_cnt (.clk(clk), .rst(rst), .inc(freeze),   .cnt(freeze_cnt));
endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// tb_pipe_ctrl_gen: directed checks of pipe_ctrl_gen (default build and an 8-lane, 2-bit-counter build)
module tb_pipe_ctrl_gen;
  import pipe_ctrl_pkg::*;
  logic clk = 1'b0, rst, alu_out, dm_ready;
  logic [4:0] op, rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;
  logic stall, next_pc_sel, flush, D_rs1_data_sel, D_rs2_data_sel;
  logic [4:0] E_op, W_rd_index;
  logic [2:0] E_f3, W_f3;
  logic [6:0] E_f7;
  logic [1:0] E_rs1_data_sel, E_rs2_data_sel;
  logic E_alu_op1_sel, E_alu_op2_sel, E_jb_op1_sel, M_dm_r_en, W_wb_en, W_wb_data_sel;
  logic [3:0] M_dm_w_en;
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
  logic [7:0] b_w_en;
  logic [1:0] b_stall_cnt;
  logic [41:0] unused_b;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  pipe_ctrl_gen dut (
    .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .alu_out(alu_out), .dm_ready(dm_ready), .stall(stall), .next_pc_sel(next_pc_sel),
    .flush(flush), .D_rs1_data_sel(D_rs1_data_sel), .D_rs2_data_sel(D_rs2_data_sel),
    .E_op(E_op), .E_f3(E_f3), .E_f7(E_f7), .E_rs1_data_sel(E_rs1_data_sel),
    .E_rs2_data_sel(E_rs2_data_sel), .E_alu_op1_sel(E_alu_op1_sel), .E_alu_op2_sel(E_alu_op2_sel),
    .E_jb_op1_sel(E_jb_op1_sel), .M_dm_w_en(M_dm_w_en), .M_dm_r_en(M_dm_r_en), .W_f3(W_f3),
    .W_wb_en(W_wb_en), .W_rd_index(W_rd_index), .W_wb_data_sel(W_wb_data_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  pipe_ctrl_gen #(.RIDX_W(5), .DM_BYTES(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .alu_out(alu_out), .dm_ready(dm_ready), .stall(unused_b[0]), .next_pc_sel(unused_b[1]),
    .flush(unused_b[2]), .D_rs1_data_sel(unused_b[3]), .D_rs2_data_sel(unused_b[4]),
    .E_op(unused_b[9:5]), .E_f3(unused_b[12:10]), .E_f7(unused_b[19:13]),
    .E_rs1_data_sel(unused_b[21:20]), .E_rs2_data_sel(unused_b[23:22]),
    .E_alu_op1_sel(unused_b[24]), .E_alu_op2_sel(unused_b[25]), .E_jb_op1_sel(unused_b[26]),
    .M_dm_w_en(b_w_en), .M_dm_r_en(unused_b[27]), .W_f3(unused_b[30:28]),
    .W_wb_en(unused_b[31]), .W_rd_index(unused_b[36:32]), .W_wb_data_sel(unused_b[37]),
    .stall_cnt(b_stall_cnt), .flush_cnt(unused_b[39:38]), .freeze_cnt(unused_b[41:40])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [4:0] o, input logic [2:0] a, input logic [6:0] b,
                     input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    op = o; f3 = a; f7 = b; rd = d; rs1 = s1; rs2 = s2;
    #1;
  endtask

  task automatic nop();
    ins(OPIMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    rst = 1'b1; dm_ready = 1'b1; alu_out = 1'b0;
    nop();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_e_op", E_op, 0);
    chk("rst_rs1_sel", E_rs1_data_sel, 2);
    chk("rst_rs2_sel", E_rs2_data_sel, 2);
    chk("rst_op1_sel", E_alu_op1_sel, 0);
    chk("rst_op2_sel", E_alu_op2_sel, 1);
    chk("rst_jb_sel", E_jb_op1_sel, 1);
    chk("rst_wb_sel", W_wb_data_sel, 1);
    chk("rst_wb_en", W_wb_en, 0);
    chk("rst_w_en", M_dm_w_en, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    // load-use: lw x5 ; add x6,x5,x7
    ins(LOAD, 3'b010, 7'd0, 5'd5, 5'd1, 5'd0);
    tick();
    ins(OP, 3'd0, 7'd0, 5'd6, 5'd5, 5'd7);
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble_op", E_op, 0);
    chk("lu_bubble_stall", stall, 0);
    chk("lu_cnt", stall_cnt, 1);
    tick();
    ins(OP, 3'd0, 7'd0, 5'd8, 5'd5, 5'd0);
    chk("lu_e_op", E_op, OP);
    chk("lu_wfwd", E_rs1_data_sel, FWD_W);
    chk("lu_rs2_rf", E_rs2_data_sel, FWD_RF);
    chk("lu_w_sel", W_wb_data_sel, 0);
    chk("lu_w_rd", W_rd_index, 5);
    chk("lu_w_en", W_wb_en, 1);
    chk("d_bypass1", D_rs1_data_sel, 1);
    chk("d_bypass2", D_rs2_data_sel, 0);
    // M forwarding: add x3,x1,x2 ; sub x4,x3,x3
    tick();
    ins(OP, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2);
    tick();
    ins(OP, 3'd0, 7'h20, 5'd4, 5'd3, 5'd3);
    tick();
    nop();
    chk("mfwd_rs1", E_rs1_data_sel, FWD_M);
    chk("mfwd_rs2", E_rs2_data_sel, FWD_M);
    chk("mfwd_f7", E_f7, 7'h20);
    tick();
    ins(OP, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2);
    tick();
    ins(OP, 3'd0, 7'h20, 5'd4, 5'd0, 5'd0);
    tick();
    chk("x0_rs1", E_rs1_data_sel, FWD_RF);
    chk("x0_rs2", E_rs2_data_sel, FWD_RF);
    // M over W precedence: add x3 ; add x3 ; add x9,x3,x0
    ins(OP, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2);
    tick();
    tick();
    ins(OP, 3'd0, 7'd0, 5'd9, 5'd3, 5'd0);
    tick();
    chk("fwd_prec", E_rs1_data_sel, FWD_M);
    // taken branch
    ins(BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2);
    tick();
    alu_out = 1'b1;
    ins(OPIMM, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0);
    chk("br_npc", next_pc_sel, 1);
    chk("br_flush", flush, 1);
    chk("br_cnt0", flush_cnt, 0);
    tick();
    chk("br_npc_off", next_pc_sel, 0);
    chk("br_bubble", E_op, 0);
    chk("br_cnt1", flush_cnt, 1);
    alu_out = 1'b0;
    ins(BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2);
    tick();
    chk("nt_npc", next_pc_sel, 0);
    chk("nt_flush", flush, 0);
    ins(OPIMM, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0);
    tick();
    chk("nt_next_op", E_op, OPIMM);
    chk("nt_cnt", flush_cnt, 1);
    // memory wait: addi x10 ; sw ; jal
    ins(OPIMM, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0);
    tick();
    ins(STORE, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2);
    tick();
    ins(JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0);
    tick();
    dm_ready = 1'b0;
    nop();
    chk("mw0_w_en", M_dm_w_en, 4'hF);
    chk("mw0_w_en8", b_w_en, 8'h0F);
    chk("mw0_stall", stall, 1);
    chk("mw0_npc", next_pc_sel, 0);
    chk("mw0_flush", flush, 0);
    chk("mw0_wb_en", W_wb_en, 1);
    chk("mw0_w_rd", W_rd_index, 10);
    for (int i = 1; i < 3; i++) begin
      tick();
      chk("mw_w_en", M_dm_w_en, 4'hF);
      chk("mw_stall", stall, 1);
      chk("mw_wb_en", W_wb_en, 0);
      chk("mw_fcnt", freeze_cnt, i);
    end
    tick();
    dm_ready = 1'b1;
    #1;
    chk("mwr_w_en", M_dm_w_en, 4'hF);
    chk("mwr_fcnt", freeze_cnt, 3);
    chk("mwr_npc", next_pc_sel, 1);
    chk("mwr_wb_en", W_wb_en, 0);
    chk("mwr_stall", stall, 0);
    tick();
    chk("mwa_w_en", M_dm_w_en, 0);
    chk("mwa_fcnt", freeze_cnt, 3);
    chk("mwa_flush_cnt", flush_cnt, 2);
    chk("mwa_bubble", E_op, 0);
    // store widths: sd, sb, sh, f3=111
    ins(STORE, 3'b011, 7'd0, 5'd0, 5'd1, 5'd2);
    tick();
    ins(STORE, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2);
    tick();
    ins(STORE, 3'b001, 7'd0, 5'd0, 5'd1, 5'd2);
    chk("sd_4lane", M_dm_w_en, 0);
    chk("sd_8lane", b_w_en, 8'hFF);
    tick();
    ins(STORE, 3'b111, 7'd0, 5'd0, 5'd1, 5'd2);
    chk("sb", M_dm_w_en, 4'h1);
    tick();
    nop();
    chk("sh", M_dm_w_en, 4'h3);
    tick();
    chk("st_bad_f3", M_dm_w_en, 0);
    // four more load-use events: saturation of the 2-bit counter
    for (int i = 0; i < 4; i++) begin
      ins(LOAD, 3'b010, 7'd0, 5'd5, 5'd1, 5'd0);
      tick();
      if (i % 2 == 1) ins(OP, 3'd0, 7'd0, 5'd6, 5'd7, 5'd5);
      else ins(OP, 3'd0, 7'd0, 5'd6, 5'd5, 5'd7);
      chk("lu_loop_stall", stall, 1);
      tick();
      tick();
      nop();
    end
    chk("stall_cnt32", stall_cnt, 5);
    chk("stall_cnt_sat", b_stall_cnt, 3);
    ins(LOAD, 3'b010, 7'd0, 5'd5, 5'd1, 5'd0);
    tick();
    ins(OP, 3'd0, 7'd0, 5'd6, 5'd7, 5'd8);
    chk("lu_nomatch", stall, 0);
    ins(JAL, 3'd0, 7'd0, 5'd1, 5'd5, 5'd5);
    chk("lu_jal_norS", stall, 0);
    // reset during a load freeze
    nop();
    tick();
    dm_ready = 1'b0;
    #1;
    chk("ld_freeze_stall", stall, 1);
    chk("ld_r_en", M_dm_r_en, 1);
    tick();
    chk("ld_fcnt", freeze_cnt, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rf_stall", stall, 0);
    chk("rf_r_en", M_dm_r_en, 0);
    chk("rf_stall_cnt", stall_cnt, 0);
    chk("rf_flush_cnt", flush_cnt, 0);
    chk("rf_freeze_cnt", freeze_cnt, 0);
    chk("rf_b_stall_cnt", b_stall_cnt, 0);
    chk("rf_e_op", E_op, 0);
    chk("rf_rs1_sel", E_rs1_data_sel, 2);
    chk("rf_wb_en", W_wb_en, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
